// File: rtl/lighthouse_event_arbiter.sv
// Merges per-channel edge events into one 32-bit timer-FIFO write port via one-entry holding registers.
// Optional build macro LIGHTHOUSE_ARB_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module lighthouse_event_arbiter #(
  parameter int CHANNELS = 3,
  parameter int CH_BITS  = 3
) (
  input  logic                   clk_48,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    ch_enable,
  input  logic [CHANNELS-1:0]    ch_rise,
  input  logic [CHANNELS-1:0]    ch_fall,
  input  logic [24*CHANNELS-1:0] ch_length,
  input  logic                   fifo_ready,
  output logic [31:0]            fifo_write_data,
  output logic                   fifo_write_strobe,
  output logic [CHANNELS-1:0]    pending,
  output logic [15:0]            drop_count,
  output logic                   overflow
);

  // hold[i] = {rise flag, 24-bit length}
  logic [24:0]         hold [CHANNELS];
  logic [24:0]         load_word [CHANNELS];
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] granted;
  logic                grant_valid;
  logic                grant_en;
  logic [CH_BITS-1:0]  grant_idx;
  logic [24:0]         grant_word;
  logic [4:0]          drop_inc;
  logic [16:0]         drop_sum;

`ifdef LIGHTHOUSE_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_BITS'(i);
      end
    end
  end
`else
  logic [CH_BITS-1:0] ptr;

  // Scan offsets from far to near so the nearest pending channel after ptr wins.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = CHANNELS; k >= 1; k--) begin
      cand = (int'(ptr) + k) % CHANNELS;
      if (pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_BITS'(cand);
      end
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      ptr <= CH_BITS'(CHANNELS - 1);
    end else if (grant_en) begin
      ptr <= grant_idx;
    end
  end
`endif

  assign grant_en = grant_valid & fifo_ready;

  always_comb begin
    granted    = '0;
    grant_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == CH_BITS'(i)) begin
        granted[i] = grant_en;
        grant_word = hold[i];
      end
    end
  end

  // A busy channel frees up in the same cycle it is granted, so a new event can load then.
  always_comb begin
    load     = '0;
    drop_inc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load_word[i] = {~ch_fall[i], ch_length[24*i +: 24]};
      if (ch_enable[i] && (ch_rise[i] || ch_fall[i])) begin
        if (!pending[i] || granted[i]) begin
          load[i] = 1'b1;
          if (ch_rise[i] && ch_fall[i]) drop_inc = drop_inc + 5'd1;
        end else begin
          drop_inc = drop_inc + 5'(ch_rise[i]) + 5'(ch_fall[i]);
        end
      end
    end
  end

  assign drop_sum = {1'b0, drop_count} + 17'(drop_inc);

  always_ff @(posedge clk_48) begin
    if (reset) begin
      pending <= '0;
      for (int i = 0; i < CHANNELS; i++) hold[i] <= '0;
    end else begin
      pending <= (pending & ~granted) | load;
      for (int i = 0; i < CHANNELS; i++) begin
        if (load[i]) hold[i] <= load_word[i];
      end
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      fifo_write_data   <= '0;
      fifo_write_strobe <= 1'b0;
      drop_count        <= '0;
      overflow          <= 1'b0;
    end else begin
      fifo_write_strobe <= grant_en;
      if (grant_en) fifo_write_data <= {grant_word[24], 7'(grant_idx), grant_word[23:0]};
      if (drop_inc != 5'd0) begin
        overflow   <= 1'b1;
        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

endmodule
